fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage. It owns the PC register and chooses the next PC: sequential (PC+4), branch target buffer (BTB) predicted target, or redirect from branch resolution. On a mispredict it generates the flush/bubble sequence. It also issues the BTB update writes. It sits between the hazard unit, the BTB/instruction memory and the execute-stage branch resolver.

---
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: owns the PC and selects the next
// fetch address (sequential, BTB prediction or branch redirect). It also
// drives the mispredict flush sequence, the BTB update writes and the
// saturating branch/mispredict performance counters.
module fetch_ctrl #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    STALL_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_in,
    input  logic                  btb_hit,
    input  logic [DATA_WIDTH-1:0] btb_trgt,
    input  logic                  resolve_valid,
    input  logic [DATA_WIDTH-1:0] resolve_pc,
    input  logic                  resolve_taken,
    input  logic [DATA_WIDTH-1:0] resolve_trgt,
    input  logic                  resolve_pred_taken,
    input  logic [DATA_WIDTH-1:0] resolve_pred_trgt,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  fetch_valid,
    output logic                  pred_taken,
    output logic                  flush,
    output logic                  btb_write,
    output logic [DATA_WIDTH-1:0] btb_wr_pc,
    output logic [DATA_WIDTH-1:0] btb_wr_trgt,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Wide enough to hold STALL_CYCLES-1 (at least one bit).
    localparam int FCW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    logic [1:0]            state_q, state_d;
    logic [FCW-1:0]        fcnt_q, fcnt_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  btb_write_q, btb_write_d;
    logic [DATA_WIDTH-1:0] btb_wr_pc_q, btb_wr_pc_d;
    logic [DATA_WIDTH-1:0] btb_wr_trgt_q, btb_wr_trgt_d;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  mispredict_cnt_q, mispredict_cnt_d;

    logic in_run;
    logic accept;
    logic mispredict;
    logic btb_update;

    // Resolve qualification: only branches seen in RUN are on the correct path.
    always_comb begin
        in_run     = (state_q == ST_RUN);
        accept     = in_run && resolve_valid;
        mispredict = accept &&
                     ((resolve_taken != resolve_pred_taken) ||
                      (resolve_taken && (resolve_trgt != resolve_pred_trgt)));
        btb_update = accept && resolve_taken &&
                     (!resolve_pred_taken || (resolve_trgt != resolve_pred_trgt));
    end

    // Next-state, next-PC, BTB write and counter logic.
    always_comb begin
        state_d          = state_q;
        fcnt_d           = fcnt_q;
        pc_d             = pc_q;
        btb_write_d      = 1'b0;
        btb_wr_pc_d      = btb_wr_pc_q;
        btb_wr_trgt_d    = btb_wr_trgt_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mispredict) begin
                    pc_d    = resolve_taken ? resolve_trgt : resolve_pc + DATA_WIDTH'(4);
                    state_d = ST_FLUSH;
                    fcnt_d  = FCW'(STALL_CYCLES - 1);
                end else if (!stall_in) begin
                    pc_d = btb_hit ? btb_trgt : pc_q + DATA_WIDTH'(4);
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - FCW'(1);
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (btb_update) begin
            btb_write_d   = 1'b1;
            btb_wr_pc_d   = resolve_pc;
            btb_wr_trgt_d = resolve_trgt;
        end

        if (accept && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        end
        if (mispredict && (mispredict_cnt_q != '1)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_BOOT;
            fcnt_q           <= '0;
            pc_q             <= RESET_PC;
            btb_write_q      <= 1'b0;
            btb_wr_pc_q      <= '0;
            btb_wr_trgt_q    <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            pc_q             <= pc_d;
            btb_write_q      <= btb_write_d;
            btb_wr_pc_q      <= btb_wr_pc_d;
            btb_wr_trgt_q    <= btb_wr_trgt_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // Output mapping; fetch_valid/flush decode the registered state.
    always_comb begin
        pc             = pc_q;
        fetch_valid    = (state_q == ST_RUN);
        pred_taken     = (state_q == ST_RUN) && btb_hit;
        flush          = (state_q == ST_FLUSH);
        btb_write      = btb_write_q;
        btb_wr_pc      = btb_wr_pc_q;
        btb_wr_trgt    = btb_wr_trgt_q;
        branch_cnt     = branch_cnt_q;
        mispredict_cnt = mispredict_cnt_q;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. Two instances share the stimulus inputs
// and are exercised one at a time by holding the other in reset:
//   A: RESET_PC=0x100, STALL_CYCLES=2, CNT_WIDTH=16 (main behaviour)
//   B: RESET_PC=0xFFFFFFF8, STALL_CYCLES=1, CNT_WIDTH=2 (wrap and saturation)
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_na, rst_nb;
    logic        stall_in, btb_hit, resolve_valid, resolve_taken, resolve_pred_taken;
    logic [31:0] btb_trgt, resolve_pc, resolve_trgt, resolve_pred_trgt;

    logic [31:0] pc_a, wr_pc_a, wr_trgt_a;
    logic        fv_a, pt_a, fl_a, bw_a;
    logic [15:0] br_a, mis_a;

    logic [31:0] pc_b, wr_pc_b, wr_trgt_b;
    logic        fv_b, pt_b, fl_b, bw_b;
    logic [1:0]  br_b, mis_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.DATA_WIDTH(32), .STALL_CYCLES(2), .RESET_PC(32'h100), .CNT_WIDTH(16)) u_a (
        .clk(clk), .rst_n(rst_na), .stall_in(stall_in), .btb_hit(btb_hit), .btb_trgt(btb_trgt),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_trgt(resolve_trgt), .resolve_pred_taken(resolve_pred_taken),
        .resolve_pred_trgt(resolve_pred_trgt), .pc(pc_a), .fetch_valid(fv_a), .pred_taken(pt_a),
        .flush(fl_a), .btb_write(bw_a), .btb_wr_pc(wr_pc_a), .btb_wr_trgt(wr_trgt_a),
        .branch_cnt(br_a), .mispredict_cnt(mis_a)
    );

    fetch_ctrl #(.DATA_WIDTH(32), .STALL_CYCLES(1), .RESET_PC(32'hFFFF_FFF8), .CNT_WIDTH(2)) u_b (
        .clk(clk), .rst_n(rst_nb), .stall_in(stall_in), .btb_hit(btb_hit), .btb_trgt(btb_trgt),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_trgt(resolve_trgt), .resolve_pred_taken(resolve_pred_taken),
        .resolve_pred_trgt(resolve_pred_trgt), .pc(pc_b), .fetch_valid(fv_b), .pred_taken(pt_b),
        .flush(fl_b), .btb_write(bw_b), .btb_wr_pc(wr_pc_b), .btb_wr_trgt(wr_trgt_b),
        .branch_cnt(br_b), .mispredict_cnt(mis_b)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_resolve();
        resolve_valid      = 1'b0;
        resolve_pc         = '0;
        resolve_taken      = 1'b0;
        resolve_trgt       = '0;
        resolve_pred_taken = 1'b0;
        resolve_pred_trgt  = '0;
    endtask

    task automatic test_reset();
        rst_na = 1'b0; rst_nb = 1'b0;
        stall_in = 1'b0; btb_hit = 1'b0; btb_trgt = '0;
        clear_resolve();
        step(); step();
        n_cmp++; if (pc_a !== 32'h100) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc_a, 32'h100); end
        n_cmp++; if ({fv_a, pt_a, fl_a, bw_a} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {fv_a, pt_a, fl_a, bw_a}); end
        n_cmp++; if ({br_a, mis_a, wr_pc_a, wr_trgt_a} !== '0) begin n_err++; $display("FAIL reset_regs got=%h/%h/%h/%h exp=0", br_a, mis_a, wr_pc_a, wr_trgt_a); end
        // Release: the cycle after the first rising edge is RUN at RESET_PC.
        rst_na = 1'b1;
        n_cmp++; if (fv_a !== 1'b0) begin n_err++; $display("FAIL boot_fv got=%b exp=0", fv_a); end
        step();
        n_cmp++; if (pc_a !== 32'h100 || fv_a !== 1'b1) begin n_err++; $display("FAIL run0 pc=%h fv=%b exp=100/1", pc_a, fv_a); end
        step();
        n_cmp++; if (pc_a !== 32'h104 || fv_a !== 1'b1) begin n_err++; $display("FAIL run1 pc=%h fv=%b exp=104/1", pc_a, fv_a); end
        step();
        n_cmp++; if (pc_a !== 32'h108 || fv_a !== 1'b1) begin n_err++; $display("FAIL run2 pc=%h fv=%b exp=108/1", pc_a, fv_a); end
    endtask

    task automatic test_btb_predict_and_stall();
        btb_hit = 1'b1; btb_trgt = 32'h200;
        #1;
        n_cmp++; if (pt_a !== 1'b1) begin n_err++; $display("FAIL pred_taken got=%b exp=1", pt_a); end
        step();
        n_cmp++; if (pc_a !== 32'h200) begin n_err++; $display("FAIL btb_jump got=%h exp=200", pc_a); end
        stall_in = 1'b1; btb_trgt = 32'h400;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (pc_a !== 32'h200 || fv_a !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d] pc=%h fv=%b exp=200/1", i, pc_a, fv_a); end
        end
        stall_in = 1'b0;
        step();
        n_cmp++; if (pc_a !== 32'h400) begin n_err++; $display("FAIL btb_after_stall got=%h exp=400", pc_a); end
        btb_hit = 1'b0;
        #1;
        n_cmp++; if (pt_a !== 1'b0) begin n_err++; $display("FAIL pred_taken_off got=%b exp=0", pt_a); end
    endtask

    task automatic test_taken_mispredict();
        resolve_valid = 1'b1; resolve_pc = 32'h300; resolve_taken = 1'b1;
        resolve_trgt = 32'h500; resolve_pred_taken = 1'b0; resolve_pred_trgt = '0;
        step();
        clear_resolve();
        n_cmp++; if (pc_a !== 32'h500 || fl_a !== 1'b1 || fv_a !== 1'b0) begin n_err++; $display("FAIL mp_flush1 pc=%h fl=%b fv=%b exp=500/1/0", pc_a, fl_a, fv_a); end
        n_cmp++; if (bw_a !== 1'b1 || wr_pc_a !== 32'h300 || wr_trgt_a !== 32'h500) begin n_err++; $display("FAIL mp_btbw bw=%b %h->%h exp=1 300->500", bw_a, wr_pc_a, wr_trgt_a); end
        n_cmp++; if (br_a !== 16'd1 || mis_a !== 16'd1) begin n_err++; $display("FAIL mp_cnt br=%0d mis=%0d exp=1/1", br_a, mis_a); end
        step();
        n_cmp++; if (pc_a !== 32'h500 || fl_a !== 1'b1 || fv_a !== 1'b0 || bw_a !== 1'b0) begin n_err++; $display("FAIL mp_flush2 pc=%h fl=%b fv=%b bw=%b exp=500/1/0/0", pc_a, fl_a, fv_a, bw_a); end
        step();
        n_cmp++; if (pc_a !== 32'h500 || fl_a !== 1'b0 || fv_a !== 1'b1) begin n_err++; $display("FAIL mp_resume pc=%h fl=%b fv=%b exp=500/0/1", pc_a, fl_a, fv_a); end
    endtask

    task automatic test_correct_prediction();
        // Correctly predicted taken branch: counted, no flush, no BTB write.
        resolve_valid = 1'b1; resolve_pc = 32'h480; resolve_taken = 1'b1;
        resolve_trgt = 32'h700; resolve_pred_taken = 1'b1; resolve_pred_trgt = 32'h700;
        step();
        clear_resolve();
        n_cmp++; if (pc_a !== 32'h504 || fl_a !== 1'b0 || bw_a !== 1'b0) begin n_err++; $display("FAIL ok_pred pc=%h fl=%b bw=%b exp=504/0/0", pc_a, fl_a, bw_a); end
        n_cmp++; if (br_a !== 16'd2 || mis_a !== 16'd1) begin n_err++; $display("FAIL ok_cnt br=%0d mis=%0d exp=2/1", br_a, mis_a); end
    endtask

    task automatic test_nottaken_mispredict_and_reset();
        resolve_valid = 1'b1; resolve_pc = 32'h300; resolve_taken = 1'b0;
        resolve_trgt = 32'h900; resolve_pred_taken = 1'b1; resolve_pred_trgt = 32'h900;
        stall_in = 1'b1;
        step();
        stall_in = 1'b0;
        // Leave a would-be mispredict asserted during FLUSH: it must be ignored.
        resolve_taken = 1'b1; resolve_pred_taken = 1'b0;
        n_cmp++; if (pc_a !== 32'h304 || fl_a !== 1'b1 || bw_a !== 1'b0) begin n_err++; $display("FAIL nt_flush1 pc=%h fl=%b bw=%b exp=304/1/0", pc_a, fl_a, bw_a); end
        n_cmp++; if (br_a !== 16'd3 || mis_a !== 16'd2) begin n_err++; $display("FAIL nt_cnt br=%0d mis=%0d exp=3/2", br_a, mis_a); end
        step();
        n_cmp++; if (pc_a !== 32'h304 || fl_a !== 1'b1 || bw_a !== 1'b0 || br_a !== 16'd3 || mis_a !== 16'd2) begin n_err++; $display("FAIL flush_ignore pc=%h fl=%b bw=%b br=%0d mis=%0d exp=304/1/0/3/2", pc_a, fl_a, bw_a, br_a, mis_a); end
        // Reset during the second FLUSH cycle.
        rst_na = 1'b0;
        step();
        clear_resolve();
        n_cmp++; if (pc_a !== 32'h100 || fl_a !== 1'b0 || bw_a !== 1'b0 || fv_a !== 1'b0) begin n_err++; $display("FAIL mid_flush_rst pc=%h fl=%b bw=%b fv=%b exp=100/0/0/0", pc_a, fl_a, bw_a, fv_a); end
        n_cmp++; if (br_a !== 16'd0 || mis_a !== 16'd0) begin n_err++; $display("FAIL mid_flush_rst_cnt br=%0d mis=%0d exp=0/0", br_a, mis_a); end
        rst_na = 1'b1;
        step();
        n_cmp++; if (fv_a !== 1'b1 || pc_a !== 32'h100) begin n_err++; $display("FAIL rst_boot_run fv=%b pc=%h exp=1/100", fv_a, pc_a); end
        // A qualifying resolve coinciding with reset must not produce a write.
        resolve_valid = 1'b1; resolve_pc = 32'h100; resolve_taken = 1'b1; resolve_trgt = 32'h800;
        rst_na = 1'b0;
        step();
        clear_resolve();
        n_cmp++; if (bw_a !== 1'b0 || wr_pc_a !== 32'h0 || fl_a !== 1'b0) begin n_err++; $display("FAIL rst_drop_btbw bw=%b wr_pc=%h fl=%b exp=0/0/0", bw_a, wr_pc_a, fl_a); end
    endtask

    task automatic test_wrap_and_saturation();
        // Instance B: pc wrap past 2^32 and 2-bit counter saturation.
        rst_nb = 1'b1;
        step();
        n_cmp++; if (pc_b !== 32'hFFFF_FFF8 || fv_b !== 1'b1) begin n_err++; $display("FAIL b_run0 pc=%h fv=%b exp=fffffff8/1", pc_b, fv_b); end
        step();
        n_cmp++; if (pc_b !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL b_run1 got=%h exp=fffffffc", pc_b); end
        step();
        n_cmp++; if (pc_b !== 32'h0) begin n_err++; $display("FAIL pc_wrap got=%h exp=0", pc_b); end
        for (int i = 0; i < 4; i++) begin
            resolve_valid = 1'b1; resolve_pc = 32'h10; resolve_taken = 1'b0; resolve_pred_taken = 1'b1;
            step();
            clear_resolve();
            n_cmp++; if (fl_b !== 1'b1 || pc_b !== 32'h14) begin n_err++; $display("FAIL b_flush[%0d] fl=%b pc=%h exp=1/14", i, fl_b, pc_b); end
            n_cmp++; if (mis_b !== ((i < 3) ? 2'(i + 1) : 2'd3) || br_b !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin n_err++; $display("FAIL b_sat[%0d] mis=%0d br=%0d exp=%0d", i, mis_b, br_b, (i < 3) ? i + 1 : 3); end
            step();
            n_cmp++; if (fl_b !== 1'b0 || fv_b !== 1'b1) begin n_err++; $display("FAIL b_flush1cyc[%0d] fl=%b fv=%b exp=0/1", i, fl_b, fv_b); end
        end
    endtask

    initial begin
        test_reset();
        test_btb_predict_and_stall();
        test_taken_mispredict();
        test_correct_prediction();
        test_nottaken_mispredict_and_reset();
        test_wrap_and_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
